// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Shared datapath widths and ALU EXE_CMD encodings for the MIPS pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int DW = 32;
  localparam int RW = 5;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd2;
  localparam logic [3:0] AND = 4'd4;
  localparam logic [3:0] OR  = 4'd5;
  localparam logic [3:0] NOR = 4'd6;
  localparam logic [3:0] XOR = 4'd7;
  localparam logic [3:0] SLL = 4'd8;
  localparam logic [3:0] SRA = 4'd9;
  localparam logic [3:0] SRL = 4'd10;

endpackage

`default_nettype wire

// File: rtl/exe_operand_stage_fwd_mux.sv
// ============================================================================
// Module : fwd_mux
// One operand's forwarding select: MEM result over WB value over register file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fwd_mux #(
  parameter int DW = mips_pkg::DW,
  parameter int RW = mips_pkg::RW
) (
  input  logic          fwd_en,
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_val,
  input  logic          mem_wb_en,
  input  logic [RW-1:0] mem_dest,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_wb_en,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_value,
  output logic [DW-1:0] out
);
  import mips_pkg::*;

  logic w_src_nz;
  logic w_mem_hit;
  logic w_wb_hit;

  // $0 is hardwired zero, so a pending write to it must never be forwarded
  assign w_src_nz  = (src != '0);
  assign w_mem_hit = fwd_en & mem_wb_en & (mem_dest == src) & w_src_nz;
  assign w_wb_hit  = fwd_en & wb_wb_en  & (wb_dest  == src) & w_src_nz;

  assign out = w_mem_hit ? mem_result :
               w_wb_hit  ? wb_value   : reg_val;

endmodule

`default_nettype wire

// File: rtl/exe_operand_stage.sv
// ============================================================================
// Module : exe_operand_stage
// ID/EXE pipeline register with MEM/WB operand forwarding and load-use detect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module exe_operand_stage #(
  parameter int DW          = mips_pkg::DW,
  parameter int RW          = mips_pkg::RW,
  parameter bit FWD_DEFAULT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          freeze,
  input  logic          flush,
  input  logic          fwd_en,
  input  logic          id_valid,
  input  logic [3:0]    id_exe_cmd,
  input  logic [DW-1:0] id_reg1,
  input  logic [DW-1:0] id_reg2,
  input  logic [DW-1:0] id_imm,
  input  logic          id_is_imm,
  input  logic [RW-1:0] id_src1,
  input  logic [RW-1:0] id_src2,
  input  logic          id_uses_src2,
  input  logic [RW-1:0] id_dest,
  input  logic          id_wb_en,
  input  logic          id_mem_r_en,
  input  logic          id_mem_w_en,
  input  logic [DW-1:0] id_pc,
  input  logic          mem_wb_en,
  input  logic [RW-1:0] mem_dest,
  input  logic [DW-1:0] mem_result,
  input  logic          wb_wb_en,
  input  logic [RW-1:0] wb_dest,
  input  logic [DW-1:0] wb_value,
  output logic [DW-1:0] val1,
  output logic [DW-1:0] val2,
  output logic [3:0]    exe_cmd,
  output logic [DW-1:0] st_val,
  output logic [RW-1:0] dest,
  output logic          wb_en,
  output logic          mem_r_en,
  output logic          mem_w_en,
  output logic [DW-1:0] pc,
  output logic          valid,
  output logic          ld_use_hazard,
  output logic [15:0]   bubble_cnt
);
  import mips_pkg::*;

  logic          r_valid;
  logic [3:0]    r_exe_cmd;
  logic [DW-1:0] r_reg1;
  logic [DW-1:0] r_reg2;
  logic [DW-1:0] r_imm;
  logic          r_is_imm;
  logic [RW-1:0] r_src1;
  logic [RW-1:0] r_src2;
  logic [RW-1:0] r_dest;
  logic          r_wb_en;
  logic          r_mem_r_en;
  logic          r_mem_w_en;
  logic [DW-1:0] r_pc;
  logic [15:0]   r_bubble_cnt;

  logic          w_fwd_en;
  logic          w_bubble;
  logic [DW-1:0] w_f1;
  logic [DW-1:0] w_f2;
  logic          w_id_match;

  // While in reset all registered sources are $0, so only the hazard path sees this
  assign w_fwd_en = rst ? fwd_en : FWD_DEFAULT;
  assign w_bubble = flush | (~freeze & ~id_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || w_bubble) begin
      r_valid    <= 1'b0;
      r_exe_cmd  <= ADD;
      r_reg1     <= '0;
      r_reg2     <= '0;
      r_imm      <= '0;
      r_is_imm   <= 1'b0;
      r_src1     <= '0;
      r_src2     <= '0;
      r_dest     <= '0;
      r_wb_en    <= 1'b0;
      r_mem_r_en <= 1'b0;
      r_mem_w_en <= 1'b0;
      r_pc       <= '0;
    end else if (!freeze) begin
      r_valid    <= 1'b1;
      r_exe_cmd  <= id_exe_cmd;
      r_reg1     <= id_reg1;
      r_reg2     <= id_reg2;
      r_imm      <= id_imm;
      r_is_imm   <= id_is_imm;
      r_src1     <= id_src1;
      r_src2     <= id_src2;
      r_dest     <= id_dest;
      r_wb_en    <= id_wb_en;
      r_mem_r_en <= id_mem_r_en;
      r_mem_w_en <= id_mem_w_en;
      r_pc       <= id_pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd1 (
    .fwd_en     (w_fwd_en),
    .src        (r_src1),
    .reg_val    (r_reg1),
    .mem_wb_en  (mem_wb_en),
    .mem_dest   (mem_dest),
    .mem_result (mem_result),
    .wb_wb_en   (wb_wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .out        (w_f1)
  );

  fwd_mux #(.DW(DW), .RW(RW)) u_fwd2 (
    .fwd_en     (w_fwd_en),
    .src        (r_src2),
    .reg_val    (r_reg2),
    .mem_wb_en  (mem_wb_en),
    .mem_dest   (mem_dest),
    .mem_result (mem_result),
    .wb_wb_en   (wb_wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .out        (w_f2)
  );

  assign val1       = w_f1;
  assign val2       = r_is_imm ? r_imm : w_f2;
  assign st_val     = w_f2;
  assign exe_cmd    = r_exe_cmd;
  assign dest       = r_dest;
  assign pc         = r_pc;
  assign valid      = r_valid;
  assign wb_en      = r_valid & r_wb_en;
  assign mem_r_en   = r_valid & r_mem_r_en;
  assign mem_w_en   = r_valid & r_mem_w_en;
  assign bubble_cnt = r_bubble_cnt;

  // Without forwarding every EXE-dest match stalls; with it only a load can't be bypassed
  assign w_id_match    = id_valid & ((id_src1 == r_dest) | (id_uses_src2 & (id_src2 == r_dest)));
  assign ld_use_hazard = wb_en & (r_dest != '0) & w_id_match & (~w_fwd_en | mem_r_en);

endmodule

`default_nettype wire
